// File: rtl/instr_mem_access_pkg.sv
// Shared definitions for the data-memory access stage: FSM states, one-hot
// load/store format bit positions and byte-enable patterns.
`ifndef XLEN
`define XLEN 32
`endif

package instr_mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Bit positions inside mem_write_fmt_i = {SW,SH,SB}
    localparam int ST_FMT_SB = 0;
    localparam int ST_FMT_SH = 1;
    localparam int ST_FMT_SW = 2;

    // Bit positions inside rd_write_fmt_i = {LHU,LBU,LW,LH,LB}
    localparam int LD_FMT_LB  = 0;
    localparam int LD_FMT_LH  = 1;
    localparam int LD_FMT_LW  = 2;
    localparam int LD_FMT_LBU = 3;
    localparam int LD_FMT_LHU = 4;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte-enables / replicated write data and
// load lane extraction with sign or zero extension.
module mem_lane_align
    import instr_mem_access_pkg::*;
#(
    parameter int DW = `XLEN
) (
    input  logic [1:0]    addr_lo,
    input  logic [2:0]    st_fmt,
    input  logic [DW-1:0] st_data,
    input  logic [4:0]    ld_fmt,
    input  logic [DW-1:0] rdata,
    output logic [3:0]    be,
    output logic [DW-1:0] wdata,
    output logic [DW-1:0] ld_data
);

    function automatic logic [DW-1:0] ext8(input logic [7:0] b, input logic sgn);
        logic signed [7:0]    b_s;
        logic signed [DW-1:0] x_s;
        b_s = b;
        x_s = b_s;
        return sgn ? x_s : DW'(b);
    endfunction

    function automatic logic [DW-1:0] ext16(input logic [15:0] h, input logic sgn);
        logic signed [15:0]   h_s;
        logic signed [DW-1:0] x_s;
        h_s = h;
        x_s = h_s;
        return sgn ? x_s : DW'(h);
    endfunction

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Halves use addr[1] only, so a misaligned half stays inside the word
    assign ld_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign ld_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be    = BE_NONE;
        wdata = '0;
        if (st_fmt[ST_FMT_SW]) begin
            be    = BE_WORD;
            wdata = st_data;
        end else if (st_fmt[ST_FMT_SH]) begin
            be    = BE_HALF << {addr_lo[1], 1'b0};
            wdata = DW'({2{st_data[15:0]}});
        end else if (st_fmt[ST_FMT_SB]) begin
            be    = BE_BYTE << addr_lo;
            wdata = DW'({4{st_data[7:0]}});
        end
    end

    always_comb begin
        ld_data = '0;
        if (ld_fmt[LD_FMT_LW])       ld_data = rdata;
        else if (ld_fmt[LD_FMT_LH])  ld_data = ext16(ld_half, 1'b1);
        else if (ld_fmt[LD_FMT_LHU]) ld_data = ext16(ld_half, 1'b0);
        else if (ld_fmt[LD_FMT_LB])  ld_data = ext8(ld_byte, 1'b1);
        else if (ld_fmt[LD_FMT_LBU]) ld_data = ext8(ld_byte, 1'b0);
    end

endmodule

// File: rtl/instr_mem_access.sv
// Memory-access stage: req/gnt/rvalid data-memory handshake with stall and
// register write-back. Optional MEM_MISALIGN_CHECK_EN adds misalign_o trapping.
module instr_mem_access
    import instr_mem_access_pkg::*;
#(
    parameter int DW = `XLEN
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic [DW-1:0] mem_addr_i,
    input  logic          mem_read_en_i,
    input  logic          mem_write_en_i,
    input  logic [DW-1:0] mem_write_data_i,
    input  logic [2:0]    mem_write_fmt_i,
    input  logic [4:0]    rd_addr_i,
    input  logic          rd_write_en_i,
    input  logic [4:0]    rd_write_fmt_i,
    input  logic [DW-1:0] rd_data_i,
    output logic          dmem_req_o,
    output logic          dmem_we_o,
    output logic [DW-1:0] dmem_addr_o,
    output logic [3:0]    dmem_be_o,
    output logic [DW-1:0] dmem_wdata_o,
    input  logic          dmem_gnt_i,
    input  logic          dmem_rvalid_i,
    input  logic [DW-1:0] dmem_rdata_i,
    output logic          halt_o,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic          misalign_o,
`endif
    output logic [4:0]    wb_rd_addr_o,
    output logic          wb_rd_write_en_o,
    output logic [DW-1:0] wb_rd_data_o
);

    state_e        state_q, state_d;
    logic          mem_op, mis_d, accept;
    logic [DW-1:0] addr_p0, wdata_p0, ld_data;
    logic [2:0]    st_fmt_p0;
    logic [4:0]    ld_fmt_p0, rd_addr_p0;
    logic          is_st_p0;
    logic [4:0]    wb_addr_d, wb_addr_p1;
    logic          vld_d, vld_p1;
    logic [DW-1:0] wb_data_d, wb_data_p1;

    assign mem_op = mem_read_en_i | mem_write_en_i;

`ifdef MEM_MISALIGN_CHECK_EN
    logic misalign_p1;
    assign mis_d =
        (mem_write_en_i && ((mem_write_fmt_i[ST_FMT_SH] && mem_addr_i[0]) ||
                            (mem_write_fmt_i[ST_FMT_SW] && (mem_addr_i[1:0] != 2'b00)))) ||
        (!mem_write_en_i && mem_read_en_i &&
            (((rd_write_fmt_i[LD_FMT_LH] || rd_write_fmt_i[LD_FMT_LHU]) && mem_addr_i[0]) ||
             (rd_write_fmt_i[LD_FMT_LW] && (mem_addr_i[1:0] != 2'b00))));
    assign misalign_o = misalign_p1;
`else
    assign mis_d = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        vld_d     = 1'b0;
        wb_addr_d = '0;
        wb_data_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && !mis_d) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end else if (!mem_op) begin
                    vld_d     = rd_write_en_i && (rd_addr_i != 5'd0);
                    wb_addr_d = rd_addr_i;
                    wb_data_d = rd_data_i;
                end
            end
            ST_REQ: begin
                if (dmem_gnt_i) begin
                    if (is_st_p0) begin
                        state_d = ST_IDLE;
                    end else if (dmem_rvalid_i) begin
                        state_d   = ST_IDLE;
                        vld_d     = (rd_addr_p0 != 5'd0);
                        wb_addr_d = rd_addr_p0;
                        wb_data_d = ld_data;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d   = ST_IDLE;
                    vld_d     = (rd_addr_p0 != 5'd0);
                    wb_addr_d = rd_addr_p0;
                    wb_data_d = ld_data;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture stage (p0) and write-back stage (p1)
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= ST_IDLE;
            addr_p0    <= '0;
            wdata_p0   <= '0;
            st_fmt_p0  <= '0;
            ld_fmt_p0  <= '0;
            rd_addr_p0 <= '0;
            is_st_p0   <= 1'b0;
            vld_p1     <= 1'b0;
            wb_addr_p1 <= '0;
            wb_data_p1 <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_p1 <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            vld_p1     <= vld_d;
            wb_addr_p1 <= wb_addr_d;
            wb_data_p1 <= wb_data_d;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_p1 <= (state_q == ST_IDLE) && mis_d;
`endif
            if (accept) begin
                addr_p0    <= mem_addr_i;
                wdata_p0   <= mem_write_data_i;
                st_fmt_p0  <= mem_write_fmt_i;
                ld_fmt_p0  <= rd_write_fmt_i;
                rd_addr_p0 <= rd_addr_i;
                is_st_p0   <= mem_write_en_i;
            end
        end
    end

    mem_lane_align #(.DW(DW)) u_align (
        .addr_lo (addr_p0[1:0]),
        .st_fmt  (st_fmt_p0),
        .st_data (wdata_p0),
        .ld_fmt  (ld_fmt_p0),
        .rdata   (dmem_rdata_i),
        .be      (dmem_be_o),
        .wdata   (dmem_wdata_o),
        .ld_data (ld_data)
    );

    assign halt_o           = (state_q != ST_IDLE);
    assign dmem_req_o       = (state_q == ST_REQ);
    assign dmem_we_o        = dmem_req_o & is_st_p0;
    assign dmem_addr_o      = {addr_p0[DW-1:2], 2'b00};
    assign wb_rd_write_en_o = vld_p1;
    assign wb_rd_addr_o     = wb_addr_p1;
    assign wb_rd_data_o     = wb_data_p1;

endmodule

// File: tb/tb_instr_mem_access.sv
// Directed bench for instr_mem_access: loads, stores, lane steering, forwarding,
// async reset mid-transaction and (when MEM_MISALIGN_CHECK_EN) misalignment.
module tb_instr_mem_access;

    localparam logic [4:0] F_LB = 5'b00001, F_LH = 5'b00010, F_LW = 5'b00100,
                           F_LBU = 5'b01000, F_LHU = 5'b10000;
    localparam logic [2:0] F_SB = 3'b001, F_SH = 3'b010, F_SW = 3'b100;

    logic        clk_i, resetn_i;
    logic [31:0] mem_addr_i, mem_write_data_i, rd_data_i;
    logic        mem_read_en_i, mem_write_en_i, rd_write_en_i;
    logic [2:0]  mem_write_fmt_i;
    logic [4:0]  rd_addr_i, rd_write_fmt_i;
    logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i, halt_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i, wb_rd_data_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  wb_rd_addr_o;
    logic        wb_rd_write_en_o;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int n_chk = 0;
    int n_bad = 0;

    int          r_hcnt, r_wbcnt, r_wbk, r_unstable;
    logic [31:0] r_wbdat, r_addr, r_wd;
    logic [4:0]  r_wbaddr;
    logic [3:0]  r_be;
    logic        r_we, r_req0;

    instr_mem_access #(.DW(32)) dut (
        .clk_i            (clk_i),
        .resetn_i         (resetn_i),
        .mem_addr_i       (mem_addr_i),
        .mem_read_en_i    (mem_read_en_i),
        .mem_write_en_i   (mem_write_en_i),
        .mem_write_data_i (mem_write_data_i),
        .mem_write_fmt_i  (mem_write_fmt_i),
        .rd_addr_i        (rd_addr_i),
        .rd_write_en_i    (rd_write_en_i),
        .rd_write_fmt_i   (rd_write_fmt_i),
        .rd_data_i        (rd_data_i),
        .dmem_req_o       (dmem_req_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_be_o        (dmem_be_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_gnt_i       (dmem_gnt_i),
        .dmem_rvalid_i    (dmem_rvalid_i),
        .dmem_rdata_i     (dmem_rdata_i),
        .halt_o           (halt_o),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_o       (misalign_o),
`endif
        .wb_rd_addr_o     (wb_rd_addr_o),
        .wb_rd_write_en_o (wb_rd_write_en_o),
        .wb_rd_data_o     (wb_rd_data_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read_en_i    = 1'b0;
        mem_write_en_i   = 1'b0;
        mem_write_fmt_i  = '0;
        rd_write_fmt_i   = '0;
        rd_addr_i        = '0;
        rd_write_en_i    = 1'b0;
        rd_data_i        = '0;
        mem_addr_i       = 32'hFFFF_FFFF;
        mem_write_data_i = 32'hFFFF_FFFF;
    endtask

    // Issue one access, grant after gw REQ cycles, rvalid rw cycles after grant.
    task automatic mem_op(input logic st, input logic [31:0] a, input logic [31:0] wd,
                          input logic [2:0] sf, input logic [4:0] lf, input logic [4:0] rd,
                          input int gw, input int rw, input logic [31:0] rdat);
        mem_addr_i       = a;
        mem_write_data_i = wd;
        mem_write_fmt_i  = sf;
        rd_write_fmt_i   = lf;
        rd_addr_i        = rd;
        rd_write_en_i    = !st;
        mem_read_en_i    = !st;
        mem_write_en_i   = st;
        step();
        clear_inputs();
        r_req0 = dmem_req_o; r_be = dmem_be_o; r_wd = dmem_wdata_o;
        r_addr = dmem_addr_o; r_we = dmem_we_o;
        r_hcnt = halt_o ? 1 : 0;
        r_wbcnt = 0; r_wbk = -1; r_unstable = 0; r_wbdat = '0; r_wbaddr = '0;
        for (int k = 0; k < 10; k++) begin
            dmem_gnt_i    = (k == gw);
            dmem_rvalid_i = !st && (k == gw + rw);
            dmem_rdata_i  = dmem_rvalid_i ? rdat : 32'h0BAD_0BAD;
            step();
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (dmem_req_o && (dmem_be_o != r_be || dmem_wdata_o != r_wd ||
                               dmem_addr_o != r_addr || dmem_we_o != r_we))
                r_unstable++;
            if (halt_o) r_hcnt++;
            if (wb_rd_write_en_o) begin
                if (r_wbcnt == 0) begin
                    r_wbk = k; r_wbdat = wb_rd_data_o; r_wbaddr = wb_rd_addr_o;
                end
                r_wbcnt++;
            end
        end
    endtask

    initial begin
        resetn_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
        clear_inputs();
        repeat (3) step();
        chk("rst_halt", 32'(halt_o), 32'd0);
        chk("rst_req", 32'(dmem_req_o), 32'd0);
        chk("rst_we", 32'(dmem_we_o), 32'd0);
        chk("rst_addr", dmem_addr_o, 32'd0);
        chk("rst_be", 32'(dmem_be_o), 32'd0);
        chk("rst_wdata", dmem_wdata_o, 32'd0);
        chk("rst_wb_en", 32'(wb_rd_write_en_o), 32'd0);
        chk("rst_wb_addr", 32'(wb_rd_addr_o), 32'd0);
        chk("rst_wb_data", wb_rd_data_o, 32'd0);

        // LW at 0x100, accepted on first edge after reset release
        resetn_i = 1'b1;
        mem_op(1'b0, 32'h100, 32'h0, 3'b0, F_LW, 5'd5, 2, 1, 32'hDEADBEEF);
        chk("lw_req0", 32'(r_req0), 32'd1);
        chk("lw_addr", r_addr, 32'h100);
        chk("lw_we", 32'(r_we), 32'd0);
        chk("lw_halt_cycles", r_hcnt, 32'd4);
        chk("lw_wb_pulses", r_wbcnt, 32'd1);
        chk("lw_wb_cycle", r_wbk, 32'd3);
        chk("lw_wb_data", r_wbdat, 32'hDEADBEEF);
        chk("lw_wb_addr", 32'(r_wbaddr), 32'd5);
        chk("lw_stable", r_unstable, 32'd0);

        mem_op(1'b0, 32'h103, 32'h0, 3'b0, F_LB, 5'd6, 0, 1, 32'h80FF_FFFF);
        chk("lb_data", r_wbdat, 32'hFFFF_FF80);
        chk("lb_halt_cycles", r_hcnt, 32'd2);
        chk("lb_wb_cycle", r_wbk, 32'd1);
        mem_op(1'b0, 32'h103, 32'h0, 3'b0, F_LBU, 5'd6, 0, 1, 32'h80FF_FFFF);
        chk("lbu_data", r_wbdat, 32'h0000_0080);
        mem_op(1'b0, 32'h102, 32'h0, 3'b0, F_LH, 5'd7, 1, 2, 32'h80FF_1234);
        chk("lh_data", r_wbdat, 32'hFFFF_80FF);
        mem_op(1'b0, 32'h102, 32'h0, 3'b0, F_LHU, 5'd7, 0, 1, 32'h80FF_1234);
        chk("lhu_data", r_wbdat, 32'h0000_80FF);
        mem_op(1'b0, 32'h101, 32'h0, 3'b0, F_LB, 5'd8, 0, 1, 32'h0000_7F00);
        chk("lb_pos_data", r_wbdat, 32'h0000_007F);

        mem_op(1'b1, 32'h102, 32'h1234, F_SH, 5'b0, 5'd0, 1, 0, 32'h0);
        chk("sh_be", 32'(r_be), 32'hC);
        chk("sh_wdata", r_wd, 32'h1234_1234);
        chk("sh_addr", r_addr, 32'h100);
        chk("sh_we", 32'(r_we), 32'd1);
        chk("sh_no_wb", r_wbcnt, 32'd0);
        chk("sh_halt_cycles", r_hcnt, 32'd2);
        chk("sh_stable", r_unstable, 32'd0);
        mem_op(1'b1, 32'h101, 32'hAB, F_SB, 5'b0, 5'd0, 0, 0, 32'h0);
        chk("sb_be", 32'(r_be), 32'h2);
        chk("sb_wdata", r_wd, 32'hABAB_ABAB);
        mem_op(1'b1, 32'h104, 32'hCAFE_F00D, F_SW, 5'b0, 5'd0, 3, 0, 32'h0);
        chk("sw_be", 32'(r_be), 32'hF);
        chk("sw_wdata", r_wd, 32'hCAFE_F00D);
        chk("sw_addr", r_addr, 32'h104);
        chk("sw_halt_cycles", r_hcnt, 32'd4);

        // gnt and rvalid together: REQ straight to IDLE
        mem_op(1'b0, 32'h200, 32'h0, 3'b0, F_LW, 5'd9, 0, 0, 32'h1357_9BDF);
        chk("gr_halt_cycles", r_hcnt, 32'd1);
        chk("gr_wb_cycle", r_wbk, 32'd0);
        chk("gr_wb_data", r_wbdat, 32'h1357_9BDF);

        mem_op(1'b0, 32'h204, 32'h0, 3'b0, F_LW, 5'd0, 0, 1, 32'h1111_2222);
        chk("x0_no_wb", r_wbcnt, 32'd0);

        // Non-memory forwarding
        rd_addr_i = 5'd7; rd_write_en_i = 1'b1; rd_data_i = 32'h55AA;
        step();
        chk("fwd_en", 32'(wb_rd_write_en_o), 32'd1);
        chk("fwd_addr", 32'(wb_rd_addr_o), 32'd7);
        chk("fwd_data", wb_rd_data_o, 32'h55AA);
        rd_addr_i = 5'd0; rd_data_i = 32'h77;
        step();
        chk("fwd_x0_en", 32'(wb_rd_write_en_o), 32'd0);
        chk("fwd_x0_data", wb_rd_data_o, 32'h77);
        clear_inputs();

        // Stray gnt/rvalid while idle
        dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h9999;
        step();
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        chk("stray_halt", 32'(halt_o), 32'd0);
        chk("stray_req", 32'(dmem_req_o), 32'd0);
        chk("stray_wb", 32'(wb_rd_write_en_o), 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
        mem_addr_i = 32'h101; mem_read_en_i = 1'b1; rd_write_fmt_i = F_LW;
        rd_addr_i = 5'd4; rd_write_en_i = 1'b1;
        step();
        clear_inputs();
        chk("mis_pulse", 32'(misalign_o), 32'd1);
        chk("mis_req", 32'(dmem_req_o), 32'd0);
        chk("mis_halt", 32'(halt_o), 32'd0);
        chk("mis_wb", 32'(wb_rd_write_en_o), 32'd0);
        step();
        chk("mis_pulse_end", 32'(misalign_o), 32'd0);
        chk("mis_req2", 32'(dmem_req_o), 32'd0);
`endif

        // Async reset while waiting for rvalid
        mem_addr_i = 32'h300; mem_read_en_i = 1'b1; rd_write_fmt_i = F_LW;
        rd_addr_i = 5'd3; rd_write_en_i = 1'b1;
        step();
        clear_inputs();
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        chk("wait_halt", 32'(halt_o), 32'd1);
        chk("wait_req", 32'(dmem_req_o), 32'd0);
        #1 resetn_i = 1'b0;
        #1;
        chk("arst_halt", 32'(halt_o), 32'd0);
        chk("arst_req", 32'(dmem_req_o), 32'd0);
        chk("arst_addr", dmem_addr_o, 32'd0);
        step();
        resetn_i = 1'b1;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h0000_0123;
        step();
        dmem_rvalid_i = 1'b0;
        chk("late_rv_wb", 32'(wb_rd_write_en_o), 32'd0);
        step();
        chk("late_rv_wb2", 32'(wb_rd_write_en_o), 32'd0);
        chk("late_rv_halt", 32'(halt_o), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
